bga_scan_sequencer: RTL

- Controller for the BGA solder-joint loopback scan. On request, drives one walking pattern across all N_PAIR output/input pin pairs, one step per pair.
- Each step holds the pattern for a programmable dwell, samples the looped-back inputs and compares them against the driven pattern.
- Accumulates failure count, first failing step and its difference vector, plus a sticky fail flag for the debug LED.
- Sits between the board-level pin bundle (top-level concatenation) and the status/LED logic.

---
 rtl/bga_scan_sequencer_pkg.sv | 35 +++
 rtl/bga_scan_sequencer_if.sv | 58 +++++
 rtl/bga_scan_compare.sv | 27 ++
 rtl/bga_scan_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bga_scan_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// bga_scan_sequencer_pkg
//
// Purpose : shared definitions for the BGA solder-joint loopback scan.
//           Holds the default pin-pair count and dwell, the index and
//           counter width derivations, the FSM state encoding and the
//           pattern-select encoding.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package bga_scan_sequencer_pkg;

    localparam int N_PAIR_DEFAULT = 86;
    localparam int DWELL_DEFAULT  = 32;

    // Width of a step index able to address n pairs (never below 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter able to hold the value n (0..n inclusive).
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // pattern_sel encoding
    localparam logic PAT_WALK_ONE  = 1'b0;
    localparam logic PAT_WALK_ZERO = 1'b1;

endpackage

// File: rtl/bga_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// bga_scan_sequencer_if
//
// Purpose : request/status bundle between the scan sequencer and the
//           status/LED logic.
// Signals : start           - single-cycle scan request
//           pattern_sel     - 0 walking-one, 1 walking-zero
//           busy, done      - scan running / one-cycle completion pulse
//           pass            - last completed scan had no failures
//           fail_cnt        - failing steps in the last scan
//           first_fail_idx  - step index of the first failure
//           first_fail_diff - driven XOR sampled at the first failure
//           fail_sticky     - any failure since reset
// Modports: master (requester / status consumer), slave (sequencer)
// ---------------------------------------------------------------------------
interface bga_scan_sequencer_if
    import bga_scan_sequencer_pkg::*;
#(
    parameter int N_PAIR = N_PAIR_DEFAULT,
    parameter int IDX_W  = idx_width(N_PAIR),
    parameter int CNT_W  = cnt_width(N_PAIR)
);

    logic              start;
    logic              pattern_sel;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  fail_cnt;
    logic [IDX_W-1:0]  first_fail_idx;
    logic [N_PAIR-1:0] first_fail_diff;
    logic              fail_sticky;

    modport master (
        output start,
        output pattern_sel,
        input  busy,
        input  done,
        input  pass,
        input  fail_cnt,
        input  first_fail_idx,
        input  first_fail_diff,
        input  fail_sticky
    );

    modport slave (
        input  start,
        input  pattern_sel,
        output busy,
        output done,
        output pass,
        output fail_cnt,
        output first_fail_idx,
        output first_fail_diff,
        output fail_sticky
    );

endinterface

// File: rtl/bga_scan_compare.sv
// ---------------------------------------------------------------------------
// bga_scan_compare
//
// Purpose : compares the driven pattern against the synchronised loopback
//           sample. Purely combinational; kept as its own block so the
//           wide XOR and OR-reduce can be pipelined later without touching
//           the sequencer.
// Ports   : pattern  in  N_PAIR  currently driven pattern
//           sampled  in  N_PAIR  synchronised loopback inputs
//           mismatch out 1       any bit differs
//           diff     out N_PAIR  pattern XOR sampled
// ---------------------------------------------------------------------------
module bga_scan_compare
    import bga_scan_sequencer_pkg::*;
#(
    parameter int N_PAIR = N_PAIR_DEFAULT
) (
    input  logic [N_PAIR-1:0] pattern,
    input  logic [N_PAIR-1:0] sampled,
    output logic              mismatch,
    output logic [N_PAIR-1:0] diff
);

    assign diff     = pattern ^ sampled;
    assign mismatch = |diff;

endmodule

// File: rtl/bga_scan_sequencer.sv
// ---------------------------------------------------------------------------
// bga_scan_sequencer
//
// Purpose : walks a one-hot (or one-cold) pattern across all pin pairs,
//           holding each step for DWELL cycles, and compares the
//           double-synchronised loopback against the driven pattern on the
//           last dwell cycle. Records failure count, first failing step and
//           its difference vector, plus a sticky fail flag.
// Ports   : clk       in   system clock
//           reset_n   in   asynchronous active-low reset
//           ctrl      slave modport of bga_scan_sequencer_if
//                          (start/pattern_sel in; busy/done/pass/status out)
//           scan_out  out  N_PAIR registered drive to the _o pins
//           scan_in   in   N_PAIR raw _i pins, asynchronous to the pattern
// ---------------------------------------------------------------------------
module bga_scan_sequencer
    import bga_scan_sequencer_pkg::*;
#(
    parameter int N_PAIR = N_PAIR_DEFAULT,
    parameter int DWELL  = DWELL_DEFAULT,
    parameter int IDX_W  = idx_width(N_PAIR),
    parameter int CNT_W  = cnt_width(N_PAIR)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bga_scan_sequencer_if.slave  ctrl,
    output logic [N_PAIR-1:0]    scan_out,
    input  logic [N_PAIR-1:0]    scan_in
);

    localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [IDX_W-1:0]  LAST_STEP  = IDX_W'(N_PAIR - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [N_PAIR-1:0] FIRST_ONE  = N_PAIR'(1);

    scan_state_t       state;
    scan_state_t       state_next;

    logic              armed;
    logic              walk_zero;
    logic [IDX_W-1:0]  step;
    logic [DW_W-1:0]   dwell_cnt;
    logic [N_PAIR-1:0] sync0;
    logic [N_PAIR-1:0] sync1;
    logic              mismatch;
    logic [N_PAIR-1:0] diff;

    logic              busy;
    logic              done;
    logic              accept;
    logic              step_end;
    logic              last_step;
    logic              fail_record;

    logic              pass;
    logic [CNT_W-1:0]  fail_cnt;
    logic [CNT_W-1:0]  fail_cnt_next;
    logic [IDX_W-1:0]  first_fail_idx;
    logic [N_PAIR-1:0] first_fail_diff;
    logic              fail_sticky;

    // During RUN the registered drive is exactly the current step pattern,
    // so it doubles as the compare reference.
    bga_scan_compare #(
        .N_PAIR (N_PAIR)
    ) u_compare (
        .pattern  (scan_out),
        .sampled  (sync1),
        .mismatch (mismatch),
        .diff     (diff)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // armed stays low for the first edge after reset release so a start
    // coinciding with deassertion is dropped.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        step_end   = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl.start && armed) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (dwell_cnt == DWELL_LAST) begin
                    step_end = 1'b1;
                    if (step == LAST_STEP) begin
                        last_step  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Failure counter update; saturates rather than wrapping so a long
    // failing scan never reads back as clean.
    always_comb begin
        fail_record   = step_end && mismatch;
        fail_cnt_next = fail_cnt;
        if (accept) begin
            fail_cnt_next = '0;
        end else if (fail_record && (fail_cnt != CNT_MAX)) begin
            fail_cnt_next = fail_cnt + CNT_W'(1);
        end
    end

    // Two-flop synchroniser for the looped-back pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0 <= '0;
            sync1 <= '0;
            armed <= 1'b0;
        end else begin
            sync0 <= scan_in;
            sync1 <= sync0;
            armed <= 1'b1;
        end
    end

    // Step/dwell counters, pattern drive and result capture. The pattern
    // advances by shifting the registered drive; walking-zero shifts in a
    // one so the single zero moves up. pass is computed from the updated
    // count so a failure on the final compare is included.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            walk_zero       <= 1'b0;
            step            <= '0;
            dwell_cnt       <= '0;
            scan_out        <= '0;
            pass            <= 1'b0;
            fail_cnt        <= '0;
            first_fail_idx  <= '0;
            first_fail_diff <= '0;
            fail_sticky     <= 1'b0;
        end else begin
            fail_cnt <= fail_cnt_next;
            if (accept) begin
                walk_zero       <= (ctrl.pattern_sel == PAT_WALK_ZERO);
                step            <= '0;
                dwell_cnt       <= '0;
                pass            <= 1'b0;
                first_fail_idx  <= '0;
                first_fail_diff <= '0;
                scan_out        <= (ctrl.pattern_sel == PAT_WALK_ZERO) ? ~FIRST_ONE : FIRST_ONE;
            end else if (busy) begin
                if (step_end) begin
                    dwell_cnt <= '0;
                    if (last_step) begin
                        scan_out <= walk_zero ? '1 : '0;
                        pass     <= (fail_cnt_next == '0);
                    end else begin
                        step     <= step + IDX_W'(1);
                        scan_out <= {scan_out[N_PAIR-2:0], walk_zero};
                    end
                end else begin
                    dwell_cnt <= dwell_cnt + DW_W'(1);
                end
                if (fail_record) begin
                    fail_sticky <= 1'b1;
                    if (fail_cnt == '0) begin
                        first_fail_idx  <= step;
                        first_fail_diff <= diff;
                    end
                end
            end
        end
    end

    assign ctrl.busy            = busy;
    assign ctrl.done            = done;
    assign ctrl.pass            = pass;
    assign ctrl.fail_cnt        = fail_cnt;
    assign ctrl.first_fail_idx  = first_fail_idx;
    assign ctrl.first_fail_diff = first_fail_diff;
    assign ctrl.fail_sticky     = fail_sticky;

endmodule
